// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : State encoding, default address width and next-state helper for
//            the 8-entry FIFO controller.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_W = 3;

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERROR = 3'b011,
        READ     = 3'b100,
        RD_ERROR = 3'b101
    } fifo_state_e;

    // Rejections outrank acceptances; a write outranks a read at each level.
    function automatic fifo_state_e next_state(
        input logic push_acc,
        input logic push_rej,
        input logic pop_acc,
        input logic pop_rej
    );
        if (push_rej)      return WR_ERROR;
        else if (pop_rej)  return RD_ERROR;
        else if (push_acc) return WRITE;
        else if (pop_acc)  return READ;
        else               return NO_OP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Brief    : ADDR_W-bit wrap-around pointer, advances by one when inc is high.
// Revision : 1.0
// ============================================================================
module fifo_ptr #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Natural overflow of the ADDR_W-bit sum gives the mod-DEPTH wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Brief    : Head/tail/count control for a 2**ADDR_W entry FIFO built on an
//            external register file. Define FIFO_ALMOST_EN to add the
//            almost_full / almost_empty flags and their threshold parameters.
// Revision : 1.0
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W   = FIFO_ADDR_W
`ifdef FIFO_ALMOST_EN
   ,parameter int unsigned AF_LEVEL = 7,
    parameter int unsigned AE_LEVEL = 1
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wAddr,
    output logic [ADDR_W-1:0] rf_rAddr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   data_count,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
`ifdef FIFO_ALMOST_EN
   ,output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int unsigned    DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    fifo_state_e     state_q;
    fifo_state_e     state_d;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_d;
    logic            wr_ack_q;
    logic            rd_ack_q;

    logic            push_ok;
    logic            pop_ok;
    logic            push_rej;
    logic            pop_rej;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign push_ok  = wr_en & ~full;
    assign pop_ok   = rd_en & ~empty;
    assign push_rej = wr_en & full;
    assign pop_rej  = rd_en & empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = next_state(push_ok, push_rej, pop_ok, pop_rej);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ack_q <= push_ok;
            rd_ack_q <= pop_ok;
        end
    end

    fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (rf_wAddr)
    );

    fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rf_rAddr)
    );

    // Full and empty are exclusive, so a rejected push and a rejected pop never
    // coincide and each error flag is exactly its error state.
    assign rf_we      = push_ok;
    assign data_count = count_q;
    assign wr_ack     = wr_ack_q;
    assign rd_ack     = rd_ack_q;
    assign wr_err     = (state_q == WR_ERROR);
    assign rd_err     = (state_q == RD_ERROR);

`ifdef FIFO_ALMOST_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Brief    : Self-checking bench for fifo_ctrl against a count/pointer model.
// Revision : 1.0
// ============================================================================
module tb_fifo_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       rf_we;
    logic [2:0] rf_wAddr;
    logic [2:0] rf_rAddr;
    logic       full;
    logic       empty;
    logic [3:0] data_count;
    logic       wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_EN
    logic       almost_full, almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state numbering: 0=INIT 1=NO_OP 2=WRITE 3=WR_ERROR 4=READ 5=RD_ERROR
    int m_cnt, m_head, m_tail, m_state;
    bit m_wack, m_werr, m_rack, m_rerr;

    fifo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .rf_we      (rf_we),
        .rf_wAddr   (rf_wAddr),
        .rf_rAddr   (rf_rAddr),
        .full       (full),
        .empty      (empty),
        .data_count (data_count),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
`ifdef FIFO_ALMOST_EN
       ,.almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_cnt = 0; m_head = 0; m_tail = 0; m_state = 0;
        m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
    endtask

    task automatic m_step(input bit wr, input bit rd);
        bit push, pop;
        push = wr && (m_cnt < DEPTH);
        pop  = rd && (m_cnt > 0);
        m_wack = push;
        m_werr = wr && !push;
        m_rack = pop;
        m_rerr = rd && !pop;
        if (m_werr)      m_state = 3;
        else if (m_rerr) m_state = 5;
        else if (push)   m_state = 2;
        else if (pop)    m_state = 4;
        else             m_state = 1;
        m_cnt  = m_cnt + int'(push) - int'(pop);
        m_tail = (m_tail + int'(push)) % DEPTH;
        m_head = (m_head + int'(pop)) % DEPTH;
    endtask

    // Drive one request pair, clock it, and leave time 1 unit after the edge.
    task automatic tick(input bit wr, input bit rd);
        wr_en = wr;
        rd_en = rd;
        @(posedge clk);
        m_step(wr, rd);
        #1;
    endtask

    task automatic pulse_reset();
        wr_en = 0; rd_en = 0;
        reset = 1; #2; reset = 0;
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1; wr_en = 0; rd_en = 0;
        @(posedge clk); #1;
        m_reset();
        checks++;
        if ({empty, full, data_count} !== {1'b1, 1'b0, 4'd0}) begin
            errors++; $display("FAIL reset_flags: got e=%b f=%b c=%0d want e=1 f=0 c=0", empty, full, data_count);
        end
        checks++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000 || int'(dut.state_q) !== 0) begin
            errors++; $display("FAIL reset_state: got acks=%b%b%b%b st=%0d want 0000 st=0", wr_ack, wr_err, rd_ack, rd_err, dut.state_q);
        end
        reset = 0;
        tick(0, 0);
        checks++;
        if (int'(dut.state_q) !== m_state) begin
            errors++; $display("FAIL reset_noop: got st=%0d want %0d", dut.state_q, m_state);
        end
    endtask

    task automatic test_fill();
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; rd_en = 0; #1;
            checks++;
            if ({rf_we, rf_wAddr} !== {1'b1, 3'(m_tail)}) begin
                errors++; $display("FAIL fill_we[%0d]: got we=%b wa=%0d want we=1 wa=%0d", i, rf_we, rf_wAddr, m_tail);
            end
            tick(1, 0);
            checks++;
            if ({wr_ack, data_count} !== {1'b1, 4'(m_cnt)}) begin
                errors++; $display("FAIL fill_ack[%0d]: got ack=%b c=%0d want ack=1 c=%0d", i, wr_ack, data_count, m_cnt);
            end
        end
        checks++;
        if ({full, empty, data_count} !== {1'b1, 1'b0, 4'd8}) begin
            errors++; $display("FAIL fill_full: got f=%b e=%b c=%0d want f=1 e=0 c=8", full, empty, data_count);
        end
        wr_en = 1; #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL overflow_we: got %b want 0", rf_we);
        end
        tick(1, 0);
        checks++;
        if ({wr_err, wr_ack, data_count, rf_wAddr} !== {1'b1, 1'b0, 4'd8, 3'd0} || int'(dut.state_q) !== 3) begin
            errors++; $display("FAIL overflow: got err=%b ack=%b c=%0d wa=%0d st=%0d want 1 0 8 0 3",
                               wr_err, wr_ack, data_count, rf_wAddr, dut.state_q);
        end
    endtask

    task automatic test_empty_pop();
        pulse_reset();
        tick(0, 1);
        checks++;
        if ({rd_err, rd_ack, rf_rAddr, data_count} !== {1'b1, 1'b0, 3'd0, 4'd0} || int'(dut.state_q) !== 5) begin
            errors++; $display("FAIL underflow: got err=%b ack=%b ra=%0d c=%0d st=%0d want 1 0 0 0 5",
                               rd_err, rd_ack, rf_rAddr, data_count, dut.state_q);
        end
        tick(1, 1);
        checks++;
        if ({rd_err, wr_ack, data_count, rf_rAddr} !== {1'b1, 1'b1, 4'd1, 3'd0} || int'(dut.state_q) !== m_state) begin
            errors++; $display("FAIL empty_both: got rerr=%b wack=%b c=%0d ra=%0d st=%0d want 1 1 1 0 %0d",
                               rd_err, wr_ack, data_count, rf_rAddr, dut.state_q, m_state);
        end
    endtask

    task automatic test_full_both();
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) tick(1, 0);
        tick(1, 1);
        checks++;
        if ({wr_err, rd_ack, wr_ack, data_count, rf_rAddr} !== {1'b1, 1'b1, 1'b0, 4'd7, 3'd1} || int'(dut.state_q) !== 3) begin
            errors++; $display("FAIL full_both: got werr=%b rack=%b wack=%b c=%0d ra=%0d st=%0d want 1 1 0 7 1 3",
                               wr_err, rd_ack, wr_ack, data_count, rf_rAddr, dut.state_q);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 0; i < 5; i++) tick(1, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, 1);
            checks++;
            if ({data_count, rf_wAddr, rf_rAddr, wr_ack, rd_ack} !== {4'd5, 3'(m_tail), 3'(m_head), 2'b11}) begin
                errors++; $display("FAIL b2b[%0d]: got c=%0d wa=%0d ra=%0d acks=%b%b want 5 %0d %0d 11",
                                   i, data_count, rf_wAddr, rf_rAddr, wr_ack, rd_ack, m_tail, m_head);
            end
        end
        wr_en = 1; rd_en = 1;
        #2 reset = 1;
        #1;
        checks++;
        if ({data_count, empty, full, rf_wAddr, rf_rAddr, wr_ack, rd_ack, wr_err, rd_err} !== {4'd0, 1'b1, 1'b0, 3'd0, 3'd0, 4'b0000}
            || int'(dut.state_q) !== 0) begin
            errors++; $display("FAIL mid_reset: got c=%0d e=%b f=%b wa=%0d ra=%0d acks=%b%b%b%b st=%0d want all clear",
                               data_count, empty, full, rf_wAddr, rf_rAddr, wr_ack, rd_ack, wr_err, rd_err, dut.state_q);
        end
        reset = 0; wr_en = 0; rd_en = 0;
        m_reset();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            int unsigned p_wr;
            bit wr, rd;
            p_wr = ((i / 40) % 2 == 0) ? 75 : 25;
            wr = ($urandom_range(0, 99) < p_wr);
            rd = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) == 0) pulse_reset();
            wr_en = wr; rd_en = rd; #1;
            checks++;
            if ({rf_we, rf_wAddr, rf_rAddr} !== {(wr && m_cnt < DEPTH), 3'(m_tail), 3'(m_head)}) begin
                errors++; $display("FAIL rnd_comb[%0d]: got we=%b wa=%0d ra=%0d want we=%b wa=%0d ra=%0d",
                                   i, rf_we, rf_wAddr, rf_rAddr, (wr && m_cnt < DEPTH), m_tail, m_head);
            end
            tick(wr, rd);
            checks++;
            if ({data_count, full, empty} !== {4'(m_cnt), (m_cnt == DEPTH), (m_cnt == 0)}) begin
                errors++; $display("FAIL rnd_count[%0d]: got c=%0d f=%b e=%b want c=%0d", i, data_count, full, empty, m_cnt);
            end
            checks++;
            if ({wr_ack, wr_err, rd_ack, rd_err} !== {m_wack, m_werr, m_rack, m_rerr} || int'(dut.state_q) !== m_state) begin
                errors++; $display("FAIL rnd_flags[%0d]: got %b%b%b%b st=%0d want %b%b%b%b st=%0d", i,
                                   wr_ack, wr_err, rd_ack, rd_err, dut.state_q, m_wack, m_werr, m_rack, m_rerr, m_state);
            end
`ifdef FIFO_ALMOST_EN
            checks++;
            if ({almost_full, almost_empty} !== {(m_cnt >= 7), (m_cnt <= 1)}) begin
                errors++; $display("FAIL rnd_almost[%0d]: got af=%b ae=%b c=%0d", i, almost_full, almost_empty, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        m_reset();
        #1;
        test_reset();
        test_fill();
        test_empty_pop();
        test_full_both();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
